// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Debounces a raw asynchronous level (button, switch, external line) into a
// clean clk-synchronous level. The raw input first passes a two-flop
// synchronizer. A four-state FSM then accepts a new level only after it has
// been seen on DEBOUNCE_CYCLES consecutive synchronized samples. A candidate
// change that drops back before qualifying is rejected and reported with a
// one-cycle glitch pulse.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive samples a new level must hold (1..65535)
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous, active-low reset
//   in_s        in   raw asynchronous input
//   out_s       out  debounced level (registered)
//   out_busy    out  high while a candidate change is being qualified
//   out_glitch  out  one-cycle pulse when a candidate change is rejected
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_s,
  output logic out_s,
  output logic out_busy,
  output logic out_glitch
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_CHECK_HIGH  = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_CHECK_LOW   = 2'd3;

  // Count value held on the sample before the one that completes
  // qualification; the counter therefore never reaches DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  // With a single required sample, the first differing sample is already
  // enough and the CHECK states are skipped entirely.
  localparam bit DIRECT_ACCEPT = (DEBOUNCE_CYCLES == 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_out;
  logic          r_glitch;

  logic [1:0]    w_state_next;
  logic [CW-1:0] w_count_next;
  logic          w_out_next;
  logic          w_glitch_next;
  logic          w_s;

  // Only the second synchronizer stage feeds the FSM.
  assign w_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in_s;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_glitch_next = 1'b0;
    case (r_state)
      ST_STABLE_LOW: begin
        if (w_s) begin
          if (DIRECT_ACCEPT) begin
            w_state_next = ST_STABLE_HIGH;
            w_count_next = CNT_ZERO;
          end else begin
            w_state_next = ST_CHECK_HIGH;
            w_count_next = CNT_ONE;
          end
        end
      end
      ST_CHECK_HIGH: begin
        if (w_s) begin
          if (r_count == CNT_LAST) begin
            w_state_next = ST_STABLE_HIGH;
            w_count_next = CNT_ZERO;
          end else begin
            w_count_next = r_count + CNT_ONE;
          end
        end else begin
          w_state_next  = ST_STABLE_LOW;
          w_count_next  = CNT_ZERO;
          w_glitch_next = 1'b1;
        end
      end
      ST_STABLE_HIGH: begin
        if (!w_s) begin
          if (DIRECT_ACCEPT) begin
            w_state_next = ST_STABLE_LOW;
            w_count_next = CNT_ZERO;
          end else begin
            w_state_next = ST_CHECK_LOW;
            w_count_next = CNT_ONE;
          end
        end
      end
      ST_CHECK_LOW: begin
        if (!w_s) begin
          if (r_count == CNT_LAST) begin
            w_state_next = ST_STABLE_LOW;
            w_count_next = CNT_ZERO;
          end else begin
            w_count_next = r_count + CNT_ONE;
          end
        end else begin
          w_state_next  = ST_STABLE_HIGH;
          w_count_next  = CNT_ZERO;
          w_glitch_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_STABLE_LOW;
        w_count_next = CNT_ZERO;
      end
    endcase
  end

  // The output follows the accepted level, which is high in STABLE_HIGH and
  // while a fall is still being qualified.
  assign w_out_next = (w_state_next == ST_STABLE_HIGH) ||
                      (w_state_next == ST_CHECK_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_STABLE_LOW;
      r_count  <= CNT_ZERO;
      r_out    <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_out    <= w_out_next;
      r_glitch <= w_glitch_next;
    end
  end

  assign out_s      = r_out;
  assign out_busy   = (r_state == ST_CHECK_HIGH) || (r_state == ST_CHECK_LOW);
  assign out_glitch = r_glitch;

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed plus randomized stimulus for input_debouncer (DEBOUNCE_CYCLES=4).
// The reference model treats the design as "a two-sample delay line followed
// by a run-length test": it counts how many consecutive delayed samples differ
// from the accepted level and accepts the new level once that run reaches
// DEBOUNCE_CYCLES; a run broken early is a rejection.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  logic in_s;
  logic out_s;
  logic out_busy;
  logic out_glitch;

  input_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_s       (in_s),
    .out_s      (out_s),
    .out_busy   (out_busy),
    .out_glitch (out_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_d1, m_d2;   // two-sample delay of the raw input
  bit m_acc;        // accepted level
  int m_run;        // consecutive delayed samples differing from m_acc
  bit m_glitch;

  int cyc = 0;
  int glitch_seen = 0;
  int toggles_seen = 0;
  int last_toggle = -1000;
  bit prev_out = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_acc = 0; m_run = 0; m_glitch = 0;
  endtask

  // One rising edge: advance the model, check all outputs 1 time unit later,
  // then present the next input value.
  task automatic step(input bit v);
    bit s;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = m_d2;
      m_glitch = 0;
      if (s == m_acc) begin
        if (m_run > 0) m_glitch = 1;
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= D) begin
          m_acc = s;
          m_run = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = in_s;
    end
    #1;
    chk("out_s", out_s, m_acc);
    chk("out_busy", out_busy, m_run > 0);
    chk("out_glitch", out_glitch, m_glitch);
    if (out_glitch === 1'b1) glitch_seen++;
    if (out_s !== prev_out) begin
      toggles_seen++;
      total++;
      assert (cyc - last_toggle >= D) else begin
        bad++;
        $error("FAIL toggle_spacing observed=%0d required>=%0d", cyc - last_toggle, D);
      end
      last_toggle = cyc;
      prev_out = out_s;
    end
    $display("cyc=%0d rst_n=%0b in_s=%0b out_s=%0b busy=%0b glitch=%0b",
             cyc, rst_n, in_s, out_s, out_busy, out_glitch);
    in_s = v;
  endtask

  // Drive level v and count edges until out_s equals v (bounded).
  task automatic edges_until_out(input bit v, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(v);
      n++;
      if (out_s === v) break;
    end
  endtask

  int n;
  int g0;
  int t0;
  int hold;
  bit lvl;

  initial begin
    rst_n = 1'b0;
    in_s  = 1'b0;
    model_reset();
    #3;
    chk("reset_out_s", out_s, 1'b0);
    chk("reset_busy", out_busy, 1'b0);
    chk("reset_glitch", out_glitch, 1'b0);
    repeat (3) step(0);
    #2 rst_n = 1'b1;
    repeat (4) step(0);

    // clean rise: in_s high before edge k -> out_s at edge k+5 (6th edge)
    in_s = 1'b1;
    edges_until_out(1'b1, n);
    chk_int("rise_latency", n, D + 2);
    repeat (3) step(1);

    // clean fall
    in_s = 1'b0;
    edges_until_out(1'b0, n);
    chk_int("fall_latency", n, D + 2);
    repeat (3) step(0);

    // glitch: 2 cycles high
    g0 = glitch_seen;
    t0 = toggles_seen;
    step(1); step(1);
    repeat (8) step(0);
    chk_int("glitch2_pulses", glitch_seen - g0, 1);

    // threshold: D-1 cycles rejected
    g0 = glitch_seen;
    repeat (D - 1) step(1);
    repeat (8) step(0);
    chk_int("thresh_short_pulses", glitch_seen - g0, 1);
    chk_int("thresh_short_toggles", toggles_seen - t0, 0);

    // threshold: exactly D cycles accepted, then fall qualified
    g0 = glitch_seen;
    repeat (D) step(1);
    repeat (12) step(0);
    chk_int("thresh_exact_toggles", toggles_seen - t0, 2);
    chk_int("thresh_exact_pulses", glitch_seen - g0, 0);

    // reset in the middle of a qualification
    step(1);
    step(1); step(1); step(1);   // busy now
    chk("pre_reset_busy", out_busy, 1'b1);
    g0 = glitch_seen;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_out_s", out_s, 1'b0);
    chk("midreset_busy", out_busy, 1'b0);
    chk("midreset_glitch", out_glitch, 1'b0);
    step(1); step(1);
    #2 rst_n = 1'b1;
    edges_until_out(1'b1, n);
    chk_int("post_reset_latency", n, D + 2);
    chk_int("reset_no_glitch", glitch_seen - g0, 0);
    repeat (3) step(1);

    // chatter: toggle every cycle for 20 cycles starting from high
    g0 = glitch_seen;
    t0 = toggles_seen;
    lvl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(lvl);
      lvl = ~lvl;
    end
    repeat (6) step(1);
    chk_int("chatter_toggles", toggles_seen - t0, 0);
    chk_int("chatter_pulses", glitch_seen - g0, 10);

    // randomized runs of random length
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      hold = $urandom_range(1, 7);
      lvl = ~lvl;
      for (int j = 0; j < hold; j++) step(lvl);
    end
    repeat (10) step(lvl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have one parameter: DEBOUNCE_CYCLES, default 16, the number of consecutive synchronized samples (legal range 1..65535) a new input level must hold before it is accepted.
REQ-002 The block SHALL have the following ports, one per line:
  clk         input   1  single clock; all state updates on its rising edge
  rst_n       input   1  asynchronous, active-low reset
  in_s        input   1  raw asynchronous input (button, switch, external line)
  out_s       output  1  debounced, clk-synchronous level that drives the downstream edge detector
  out_busy    output  1  high while a candidate level change is being qualified
  out_glitch  output  1  one-cycle pulse when a candidate change is rejected
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL pass in_s through a two-flop synchronizer (sync1 -> sync2); only sync2 (called s below) SHALL feed any other logic.
REQ-005 The block SHALL implement a four-state FSM: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
REQ-006 In STABLE_LOW with s=1, the FSM SHALL go to CHECK_HIGH and set the counter to 1; if DEBOUNCE_CYCLES=1, it SHALL go directly to STABLE_HIGH.
REQ-007 In CHECK_HIGH with s=1, the counter SHALL increment, and on the edge where it would reach DEBOUNCE_CYCLES the FSM SHALL go to STABLE_HIGH.
REQ-008 In CHECK_HIGH with s=0, the FSM SHALL return to STABLE_LOW, clear the counter and pulse out_glitch.
REQ-009 STABLE_HIGH and CHECK_LOW SHALL mirror REQ-006 to REQ-008 with levels inverted.
REQ-010 out_s SHALL be registered: 1 in STABLE_HIGH and CHECK_LOW, 0 in STABLE_LOW and CHECK_HIGH, so out_s never changes during qualification.
REQ-011 The latency from an in_s change (stable before edge k) to the out_s change SHALL be exactly DEBOUNCE_CYCLES+2 rising edges (out_s updates at edge k+DEBOUNCE_CYCLES+1).
REQ-012 out_busy SHALL be 1 exactly while the state is CHECK_HIGH or CHECK_LOW, which is DEBOUNCE_CYCLES-1 cycles for an accepted change.
REQ-013 out_glitch SHALL be registered, high for exactly one cycle after each rejection, and 0 otherwise; back-to-back rejections SHALL give separate pulses.
REQ-014 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, SHALL never wrap, and SHALL be 0 in both STABLE states.
REQ-015 A pulse on s lasting DEBOUNCE_CYCLES-1 cycles SHALL be rejected, and one lasting exactly DEBOUNCE_CYCLES cycles SHALL be accepted.
REQ-016 out_s SHALL never toggle more than once per DEBOUNCE_CYCLES cycles.

Reset
REQ-017 While rst_n=0, the block SHALL immediately and without a clock hold sync1=sync2=0, state=STABLE_LOW, counter=0, out_s=0, out_busy=0 and out_glitch=0.
REQ-018 Reset asserted mid-qualification SHALL abort that qualification with no out_glitch pulse.
REQ-019 After rst_n is released with in_s held at 1, the block SHALL qualify the input normally, so out_s rises DEBOUNCE_CYCLES+2 edges after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-020 Clean rise: rst_n=1, in_s 0->1 before edge k -> out_s=1 from edge k+5, out_busy=1 from edge k+2 to k+5 (3 cycles), out_glitch stays 0.
REQ-021 Clean fall: from out_s=1, in_s 1->0 -> out_s=0 exactly 6 edges later, out_busy pattern mirrored.
REQ-022 Glitch: in_s high for 2 cycles then low -> out_s stays 0, one out_glitch pulse, out_busy returns to 0.
REQ-023 Threshold: in_s high for 3 cycles -> rejected with out_glitch; in_s high for 4 cycles -> out_s goes to 1, then back to 0 after the fall is qualified.
REQ-024 Reset mid-check: assert rst_n=0 between edges while out_busy=1 -> all outputs 0 before the next edge; release with in_s=1 -> out_s=1 at the 6th edge after release.
REQ-025 Chatter: in_s toggles every cycle for 20 cycles -> out_s constant, out_glitch pulses repeatedly, no out_s transitions.
